// File: rtl/kid_hazard_monitor.sv
// Kid/hazard collision monitor: counts kid-over-hazard pixels each frame,
// decides hits on frame_tick and runs the alive/dying/dead/respawn life cycle.
module kid_hazard_monitor #(
    parameter int SCREEN_W      = 800,
    parameter int SCREEN_H      = 600,
    parameter int HIT_THRESH    = 4,
    parameter int DYING_FRAMES  = 32,
    parameter int INVULN_FRAMES = 60,
    parameter int FLASH_DIV     = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        frame_tick_i,
    input  logic [9:0]  col_i,
    input  logic [9:0]  row_i,
    input  logic        is_kid_i,
    input  logic        is_hazard_i,
    input  logic        restart_i,
    output logic        kid_alive_o,
    output logic        freeze_o,
    output logic        respawn_o,
    output logic        flash_o,
    output logic [9:0]  hit_x_o,
    output logic [9:0]  hit_y_o,
    output logic [15:0] death_count_o
);

    localparam int          FLASH_BIT    = $clog2(FLASH_DIV);
    localparam logic [10:0] SCREEN_W_L   = 11'(SCREEN_W);
    localparam logic [10:0] SCREEN_H_L   = 11'(SCREEN_H);
    localparam logic [11:0] HIT_THRESH_L = 12'(HIT_THRESH);
    localparam logic [7:0]  DYING_LAST   = 8'(DYING_FRAMES - 1);
    localparam logic [7:0]  INVULN_L     = 8'(INVULN_FRAMES);

    typedef enum logic [1:0] {
        ALIVE,
        DYING,
        DEAD,
        RESPAWN
    } state_e;

    state_e      state_q;
    logic [11:0] overlapCnt_q, overlapCnt_d;
    logic [9:0]  capX_q, capX_d;
    logic [9:0]  capY_q, capY_d;
    logic [7:0]  frameCnt_q;
    logic [7:0]  frameCntInc;
    logic [7:0]  invuln_q;
    logic [9:0]  hitX_q;
    logic [9:0]  hitY_q;
    logic [15:0] deathCnt_q;
    logic        kidAlive_q;
    logic        freeze_q;
    logic        respawn_q;
    logic        flash_q;
    logic        overlapPix;
    logic        hitFrame;

    // The frame_tick cycle itself never counts, so the tick can clear the counter cleanly.
    assign overlapPix = is_kid_i & is_hazard_i & ~frame_tick_i
                      & ({1'b0, col_i} < SCREEN_W_L)
                      & ({1'b0, row_i} < SCREEN_H_L);

    assign hitFrame    = (overlapCnt_q >= HIT_THRESH_L) && (invuln_q == 8'd0);
    assign frameCntInc = frameCnt_q + 8'd1;

    always_comb begin
        overlapCnt_d = overlapCnt_q;
        capX_d       = capX_q;
        capY_d       = capY_q;
        if (frame_tick_i) begin
            overlapCnt_d = 12'd0;
        end else if (overlapPix) begin
            if (overlapCnt_q != 12'hFFF) begin
                overlapCnt_d = overlapCnt_q + 12'd1;
            end
            if ((state_q == ALIVE) && (overlapCnt_q == 12'd0)) begin
                capX_d = col_i;
                capY_d = row_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overlapCnt_q <= 12'd0;
            capX_q       <= 10'd0;
            capY_q       <= 10'd0;
        end else begin
            overlapCnt_q <= overlapCnt_d;
            capX_q       <= capX_d;
            capY_q       <= capY_d;
        end
    end

    // Outputs are set on the same edge as the state change so they track the new state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ALIVE;
            frameCnt_q <= 8'd0;
            invuln_q   <= 8'd0;
            hitX_q     <= 10'd0;
            hitY_q     <= 10'd0;
            deathCnt_q <= 16'd0;
            kidAlive_q <= 1'b1;
            freeze_q   <= 1'b0;
            respawn_q  <= 1'b0;
            flash_q    <= 1'b0;
        end else begin
            respawn_q <= 1'b0;
            unique case (state_q)
                ALIVE: begin
                    if (frame_tick_i) begin
                        if (hitFrame) begin
                            state_q    <= DYING;
                            frameCnt_q <= 8'd0;
                            hitX_q     <= capX_q;
                            hitY_q     <= capY_q;
                            if (deathCnt_q != 16'hFFFF) begin
                                deathCnt_q <= deathCnt_q + 16'd1;
                            end
                            kidAlive_q <= 1'b0;
                            freeze_q   <= 1'b1;
                            flash_q    <= 1'b0;
                        end else if (invuln_q != 8'd0) begin
                            invuln_q <= invuln_q - 8'd1;
                        end
                    end
                end
                DYING: begin
                    if (frame_tick_i) begin
                        frameCnt_q <= frameCntInc;
                        if (frameCnt_q == DYING_LAST) begin
                            state_q <= DEAD;
                            flash_q <= 1'b0;
                        end else begin
                            flash_q <= frameCntInc[FLASH_BIT];
                        end
                    end
                end
                DEAD: begin
                    if (restart_i) begin
                        state_q   <= RESPAWN;
                        freeze_q  <= 1'b0;
                        respawn_q <= 1'b1;
                    end
                end
                RESPAWN: begin
                    state_q    <= ALIVE;
                    invuln_q   <= INVULN_L;
                    kidAlive_q <= 1'b1;
                end
            endcase
        end
    end

    assign kid_alive_o   = kidAlive_q;
    assign freeze_o      = freeze_q;
    assign respawn_o     = respawn_q;
    assign flash_o       = flash_q;
    assign hit_x_o       = hitX_q;
    assign hit_y_o       = hitY_q;
    assign death_count_o = deathCnt_q;

endmodule

// File: tb/tb_kid_hazard_monitor.sv
// Scoreboard bench for kid_hazard_monitor: stimulus queues expected outputs,
// a monitor pops and compares after every frame_tick, restart cycle and reset.
module tb_kid_hazard_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic [9:0]  col = 10'd0;
    logic [9:0]  row = 10'd0;
    logic        is_kid = 1'b0;
    logic        is_hazard = 1'b0;
    logic        restart = 1'b0;
    logic        kid_alive;
    logic        freeze;
    logic        respawn;
    logic        flash;
    logic [9:0]  hit_x;
    logic [9:0]  hit_y;
    logic [15:0] death_count;

    typedef struct {
        int          step;
        logic        kidAlive;
        logic        freeze;
        logic        respawn;
        logic        flash;
        logic [9:0]  hitX;
        logic [9:0]  hitY;
        logic [15:0] deaths;
    } exp_t;

    exp_t expQ[$];
    int   assertions = 0;
    int   failures = 0;
    int   stepNo = 0;
    logic presentQ = 1'b0;

    logic        eAlive = 1'b1;
    logic        eFreeze = 1'b0;
    logic        eResp = 1'b0;
    logic        eFlash = 1'b0;
    logic [9:0]  eHitX = 10'd0;
    logic [9:0]  eHitY = 10'd0;
    logic [15:0] eDeaths = 16'd0;

    kid_hazard_monitor dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .frame_tick_i  (frame_tick),
        .col_i         (col),
        .row_i         (row),
        .is_kid_i      (is_kid),
        .is_hazard_i   (is_hazard),
        .restart_i     (restart),
        .kid_alive_o   (kid_alive),
        .freeze_o      (freeze),
        .respawn_o     (respawn),
        .flash_o       (flash),
        .hit_x_o       (hit_x),
        .hit_y_o       (hit_y),
        .death_count_o (death_count)
    );

    always #5 clk = ~clk;

    task automatic pushExpected();
        exp_t e;
        e.step     = stepNo;
        e.kidAlive = eAlive;
        e.freeze   = eFreeze;
        e.respawn  = eResp;
        e.flash    = eFlash;
        e.hitX     = eHitX;
        e.hitY     = eHitY;
        e.deaths   = eDeaths;
        expQ.push_back(e);
        stepNo++;
    endtask

    task automatic cmpField(string nm, int step, logic [15:0] got, logic [15:0] want);
        assertions++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL step %0d %s: got %0d required %0d", step, nm, got, want);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL scoreboard_underflow: got 0 queued entries required at least 1");
            return;
        end
        e = expQ.pop_front();
        cmpField("kid_alive",   e.step, {15'd0, kid_alive}, {15'd0, e.kidAlive});
        cmpField("freeze",      e.step, {15'd0, freeze},    {15'd0, e.freeze});
        cmpField("respawn",     e.step, {15'd0, respawn},   {15'd0, e.respawn});
        cmpField("flash",       e.step, {15'd0, flash},     {15'd0, e.flash});
        cmpField("hit_x",       e.step, {6'd0, hit_x},      {6'd0, e.hitX});
        cmpField("hit_y",       e.step, {6'd0, hit_y},      {6'd0, e.hitY});
        cmpField("death_count", e.step, death_count,        e.deaths);
    endtask

    // Monitor: the DUT presents a new result after every frame_tick or restart cycle, and on reset.
    always @(posedge clk) presentQ <= frame_tick | restart;

    always @(negedge clk) begin
        if (presentQ && rst_n) checkOutput();
    end

    always @(negedge rst_n) begin
        #1;
        checkOutput();
    end

    task automatic drivePixels(int n, int x0, int y0, bit vertical);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            is_kid    = 1'b1;
            is_hazard = 1'b1;
            col       = vertical ? 10'(x0) : 10'(x0 + i);
            row       = vertical ? 10'(y0 + i) : 10'(y0);
        end
        @(negedge clk);
        is_kid    = 1'b0;
        is_hazard = 1'b0;
        col       = 10'd0;
        row       = 10'd0;
    endtask

    task automatic applyStimulus(bit tickOvl);
        @(negedge clk);
        frame_tick = 1'b1;
        if (tickOvl) begin
            is_kid    = 1'b1;
            is_hazard = 1'b1;
            col       = 10'd5;
            row       = 10'd5;
        end
        pushExpected();
        @(negedge clk);
        frame_tick = 1'b0;
        is_kid     = 1'b0;
        is_hazard  = 1'b0;
    endtask

    task automatic dyingTicks(int n);
        for (int k = 1; k <= n; k++) begin
            eAlive  = 1'b0;
            eFreeze = 1'b1;
            eFlash  = (k < 32) && (((k / 4) % 2) == 1);
            applyStimulus(1'b0);
        end
    endtask

    task automatic pulseRestart();
        @(negedge clk);
        restart = 1'b1;
        eAlive = 1'b0; eFreeze = 1'b0; eResp = 1'b1; eFlash = 1'b0;
        pushExpected();
        @(negedge clk);
        eAlive = 1'b1; eResp = 1'b0;
        pushExpected();
        @(negedge clk);
        pushExpected();
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic expectHit(int x, int y, int deaths);
        eAlive = 1'b0; eFreeze = 1'b1; eResp = 1'b0; eFlash = 1'b0;
        eHitX = 10'(x); eHitY = 10'(y); eDeaths = 16'(deaths);
    endtask

    initial begin
        #2;
        pushExpected();
        rst_n = 1'b0;
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        for (int f = 0; f < 3; f++) begin
            drivePixels(3, 10, 20, 1'b0);
            applyStimulus(1'b0);
        end

        drivePixels(5, 797, 30, 1'b0);
        applyStimulus(1'b0);
        drivePixels(5, 50, 597, 1'b1);
        applyStimulus(1'b0);
        drivePixels(3, 60, 40, 1'b0);
        applyStimulus(1'b1);

        drivePixels(5, 120, 340, 1'b0);
        expectHit(120, 340, 1);
        applyStimulus(1'b0);

        drivePixels(100, 300, 50, 1'b0);
        dyingTicks(32);

        drivePixels(10, 200, 200, 1'b0);
        applyStimulus(1'b0);

        pulseRestart();
        for (int f = 1; f <= 60; f++) begin
            drivePixels(10, 200, 100, 1'b0);
            applyStimulus(1'b0);
        end
        drivePixels(10, 450, 77, 1'b0);
        expectHit(450, 77, 2);
        applyStimulus(1'b0);

        for (int d = 3; d <= 7; d++) begin
            dyingTicks(32);
            pulseRestart();
            for (int f = 1; f <= 60; f++) applyStimulus(1'b0);
            drivePixels(4, 600 + d, 400 + d, 1'b0);
            expectHit(600 + d, 400 + d, d);
            applyStimulus(1'b0);
        end

        dyingTicks(5);
        @(negedge clk);
        #2;
        eAlive = 1'b1; eFreeze = 1'b0; eResp = 1'b0; eFlash = 1'b0;
        eHitX = 10'd0; eHitY = 10'd0; eDeaths = 16'd0;
        pushExpected();
        rst_n = 1'b0;
        #15;
        @(negedge clk);
        rst_n = 1'b1;

        drivePixels(4, 11, 22, 1'b0);
        expectHit(11, 22, 1);
        applyStimulus(1'b0);

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries required 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/kid_hazard_monitor.md
Name: kid_hazard_monitor

Overview:
- Consumer side of the hazard pixel interface: watches per-pixel kid and hazard flags (falling apples, spikes) during the scan and decides once per frame whether the kid was hit.
- Runs the kid life cycle: alive, dying flash, dead until restart, respawn with invulnerability.
- Sits between the hazard/kid sprite blocks and the kid motion and overlay logic; all inputs and outputs are on the pixel clock.

Parameters:
SCREEN_W, 800, visible width; overlap is counted only for col < SCREEN_W
SCREEN_H, 600, visible height; overlap is counted only for row < SCREEN_H
HIT_THRESH, 4, minimum overlapping pixels in one frame that count as a hit (1..4095)
DYING_FRAMES, 32, frames spent in DYING before DEAD (1..255)
INVULN_FRAMES, 60, frames after respawn during which hits are ignored (0..255)
FLASH_DIV, 4, frames per flash half-period during DYING (power of two, 1..128)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse in vertical blanking, once per frame
col  in  10  current scan column
row  in  10  current scan row
is_kid  in  1  kid sprite opaque at (col,row), same cycle
is_hazard  in  1  OR of all hazard flags at (col,row), same cycle
restart  in  1  restart key level, already synchronised
kid_alive  out  1  high in ALIVE only
freeze  out  1  high in DYING and DEAD; kid motion halts
respawn  out  1  one-cycle pulse on RESPAWN
flash  out  1  death flash enable
hit_x  out  10  col of the first overlapping pixel in the hit frame
hit_y  out  10  row of the first overlapping pixel in the hit frame
death_count  out  16  total deaths, saturating at 65535

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=ALIVE, kid_alive=1
  - freeze=0, respawn=0, flash=0
  - hit_x=0, hit_y=0, death_count=0
  - overlap count=0, frame counter=0, invuln=0
- Overlap pixel: is_kid & is_hazard & col<SCREEN_W & row<SCREEN_H & !frame_tick. Pixels in the frame_tick cycle are ignored.
- Overlap counter: 12-bit, saturates at 4095, increments on each overlap pixel. At every frame_tick it is evaluated with its pre-edge value, then cleared on the same edge, in every state.
- Hit coordinate capture:
  - In ALIVE, on an overlap pixel when the count is 0, latch col/row into cap_x/cap_y.
  - On the ALIVE→DYING transition, copy cap_x/cap_y to hit_x/hit_y.
  - hit_x/hit_y are otherwise held.
- ALIVE:
  - On frame_tick with count >= HIT_THRESH and invuln==0: go to DYING, frame counter=0, death_count += 1 (saturating).
  - On frame_tick otherwise: if invuln>0, decrement invuln.
  - A hit frame does not decrement invuln.
- DYING:
  - On frame_tick, the frame counter increments.
  - On the tick where the counter == DYING_FRAMES-1, go to DEAD.
  - flash = bit log2(FLASH_DIV) of the frame counter; flash is 0 outside DYING.
- DEAD:
  - When restart=1 on any cycle, go to RESPAWN on the next edge.
  - frame_tick has no effect other than clearing the overlap counter.
- RESPAWN:
  - Lasts exactly one cycle; respawn=1, kid_alive=0, freeze=0.
  - Loads invuln=INVULN_FRAMES, then next state is ALIVE.
- restart is ignored in ALIVE and DYING. Holding restart across respawn does not cause a second respawn, because ALIVE ignores restart.
- Outputs are registered decodes of state, valid on the cycle after the transition edge.
- Reset asserted mid-DYING or mid-DEAD returns to ALIVE with death_count=0.

Test Plan:
- Reset, then 3 frames with 3 overlap pixels each (HIT_THRESH=4) -> stays ALIVE, death_count=0, kid_alive=1.
- Frame with 5 overlap pixels, first at (120,340) -> on that frame_tick: DYING, freeze=1, hit_x=120, hit_y=340, death_count=1.
- From DYING, deliver 32 frame_ticks -> DEAD after the 32nd; flash toggles every 4 frames (0000 1111 …); 100 overlap pixels during DYING do not change hit_x/hit_y or death_count.
- In DEAD, pulse restart for 3 cycles:
  - respawn is high for exactly 1 cycle, then kid_alive=1.
  - Frames with 10 overlap pixels cause no death for 60 ticks.
  - On the 61st tick a 10-pixel frame causes DYING.
- Overlap pixels at col=800 or row=600, and an overlap asserted on the frame_tick cycle -> not counted, no hit.
- Assert rst_n=0 mid-DYING with death_count=7 -> immediately ALIVE, freeze=0, death_count=0, flash=0.
